fft_magnitude_loader: RTL

Converts the complex FFT bin stream into 25-bit power magnitudes and feeds them, one frame of 512 bins at a time, into the peak-extraction stage (`find_maximas`). It drives that stage's `load`/`data_in` write port and its `start` pulse. It then back-pressures the FFT until the 16-peak result for the frame is reported complete.

---
 rtl/fft_magnitude_loader.sv | 117 +++++++++++
 1 files changed

// File: rtl/fft_magnitude_loader.sv
// fft_magnitude_loader: turns complex FFT bins into saturated 25-bit power
// magnitudes and writes one BINS-long frame at a time into the peak stage.
// After the frame is written it pulses start and holds the FFT off until
// the peak stage reports its result (maxima_done).
module fft_magnitude_loader #(
  parameter int IN_W  = 13,
  parameter int MAG_W = 25,
  parameter int BINS  = 512
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      fft_valid,
  input  logic signed [IN_W-1:0]    fft_re,
  input  logic signed [IN_W-1:0]    fft_im,
  output logic                      fft_ready,
  input  logic                      maxima_done,
  output logic                      load,
  output logic [MAG_W-1:0]          mag_out,
  output logic                      start,
  output logic [$clog2(BINS)-1:0]   bin_count,
  output logic [15:0]               frame_count,
  output logic                      sat_frame
);

  localparam int CNT_W = $clog2(BINS);

  typedef enum logic [1:0] {S_COLLECT, S_DRAIN, S_START, S_WAIT} state_t;

  state_t            state, state_nxt;
  logic              drain_cnt;
  logic              start_nxt;
  logic              accept;
  logic              last_bin;
  // vld_pipe[0]: input captured, [1]: squares ready, [2]: magnitude on mag_out
  logic [2:0]        vld_pipe;
  logic [IN_W-1:0]   abs_re, abs_im;
  logic [MAG_W-1:0]  sq_re, sq_im;
  logic [MAG_W:0]    mag_sum;

  assign accept   = fft_valid & fft_ready;
  assign last_bin = accept && (bin_count == CNT_W'(BINS-1));
  assign load     = vld_pipe[2];
  assign mag_sum  = {1'b0, sq_re} + {1'b0, sq_im};

  // State register
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state <= S_COLLECT;
    else        state <= state_nxt;
  end

  // Next-state: DRAIN holds two cycles so the last load lands before start
  always_comb begin
    state_nxt = state;
    case (state)
      S_COLLECT: if (last_bin)    state_nxt = S_DRAIN;
      S_DRAIN:   if (drain_cnt)   state_nxt = S_START;
      S_START:                    state_nxt = S_WAIT;
      S_WAIT:    if (maxima_done) state_nxt = S_COLLECT;
      default:                    state_nxt = S_COLLECT;
    endcase
  end

  // Moore outputs; start is registered so it trails the last load by a cycle
  always_comb begin
    fft_ready = (state == S_COLLECT);
    start_nxt = (state == S_START);
  end

  // Control counters and the registered start pulse
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      drain_cnt   <= 1'b0;
      start       <= 1'b0;
      bin_count   <= '0;
      frame_count <= '0;
    end else begin
      drain_cnt <= (state == S_DRAIN);
      start     <= start_nxt;
      // power-of-two BINS: the natural wrap returns to 0 on the last bin
      if (accept)             bin_count   <= bin_count + CNT_W'(1);
      if (state == S_START)   frame_count <= frame_count + 16'd1;
    end
  end

  // Sticky saturation flag, cleared when the frame is handed back
  always_ff @(posedge clk or negedge reset) begin
    if (!reset)                              sat_frame <= 1'b0;
    else if (state == S_WAIT && maxima_done) sat_frame <= 1'b0;
    else if (vld_pipe[1] && mag_sum[MAG_W])  sat_frame <= 1'b1;
  end

  // Magnitude pipeline: capture |re|,|im|, square, then saturating sum
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      vld_pipe <= '0;
      abs_re   <= '0;
      abs_im   <= '0;
      sq_re    <= '0;
      sq_im    <= '0;
      mag_out  <= '0;
    end else begin
      vld_pipe <= {vld_pipe[1:0], accept};
      if (accept) begin
        // -(-4096) is 13'h1000, which read unsigned is the correct 4096
        abs_re <= fft_re[IN_W-1] ? -fft_re : fft_re;
        abs_im <= fft_im[IN_W-1] ? -fft_im : fft_im;
      end
      if (vld_pipe[0]) begin
        sq_re <= MAG_W'(abs_re) * MAG_W'(abs_re);
        sq_im <= MAG_W'(abs_im) * MAG_W'(abs_im);
      end
      if (vld_pipe[1])
        mag_out <= mag_sum[MAG_W] ? {MAG_W{1'b1}} : mag_sum[MAG_W-1:0];
    end
  end

endmodule
